// File: rtl/i2c_arb.sv
// Two-requester round-robin arbiter in front of a single I2C master.
// Holds one transaction in flight and re-issues NACKed commands after an idle gap.
module i2c_arb #(
    parameter int MAX_RETRY  = 2,
    parameter int GAP_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,

    input  logic       req0_val_i,
    output logic       req0_rdy_o,
    input  logic [6:0] req0_daddr_i,
    input  logic [7:0] req0_addr_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_wen_i,

    input  logic       req1_val_i,
    output logic       req1_rdy_o,
    input  logic [6:0] req1_daddr_i,
    input  logic [7:0] req1_addr_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_wen_i,

    output logic       rsp0_val_o,
    output logic       rsp0_err_o,
    output logic [7:0] rsp0_data_o,
    input  logic       rsp0_rdy_i,

    output logic       rsp1_val_o,
    output logic       rsp1_err_o,
    output logic [7:0] rsp1_data_o,
    input  logic       rsp1_rdy_i,

    output logic       m_val_o,
    output logic [6:0] m_daddr_o,
    output logic [7:0] m_addr_o,
    output logic [7:0] m_data_o,
    output logic       m_wen_o,
    input  logic       m_rdy_i,

    input  logic       m_rsp_val_i,
    input  logic       m_rsp_err_i,
    input  logic [7:0] m_rsp_data_i,
    output logic       m_rsp_rdy_o,

    output logic       busy_o
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wen_q, wen_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          pick;

    // On a tie the requester that did not complete last wins.
    always_comb begin
        if (req0_val_i && req1_val_i) begin
            pick = ~last_grant_q;
        end else begin
            pick = req1_val_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        retry_d      = retry_q;
        gap_d        = gap_q;
        daddr_d      = daddr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req0_val_i || req1_val_i) begin
                    grant_d = pick;
                    daddr_d = pick ? req1_daddr_i : req0_daddr_i;
                    addr_d  = pick ? req1_addr_i  : req0_addr_i;
                    wdata_d = pick ? req1_data_i  : req0_data_i;
                    wen_d   = pick ? req1_wen_i   : req0_wen_i;
                    retry_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_rdy_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_rsp_val_i) begin
                    err_d   = m_rsp_err_i;
                    rdata_d = m_rsp_data_i;
                    if (m_rsp_err_i && (retry_q < RETRY_MAX)) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_RESP: begin
                if (grant_q ? rsp1_rdy_i : rsp0_rdy_i) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            retry_q      <= '0;
            gap_q        <= '0;
            daddr_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            retry_q      <= retry_d;
            gap_q        <= gap_d;
            daddr_q      <= daddr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Ready is gated by reset so nothing looks accepted while rst_ni is low.
    always_comb begin
        req0_rdy_o  = rst_ni && (state_q == S_IDLE) && req0_val_i && !pick;
        req1_rdy_o  = rst_ni && (state_q == S_IDLE) && req1_val_i && pick;
        m_val_o     = (state_q == S_ISSUE);
        m_daddr_o   = daddr_q;
        m_addr_o    = addr_q;
        m_data_o    = wdata_q;
        m_wen_o     = wen_q;
        m_rsp_rdy_o = (state_q == S_WAIT);
        busy_o      = (state_q != S_IDLE);
        rsp0_val_o  = (state_q == S_RESP) && !grant_q;
        rsp1_val_o  = (state_q == S_RESP) && grant_q;
        rsp0_err_o  = rsp0_val_o && err_q;
        rsp1_err_o  = rsp1_val_o && err_q;
        rsp0_data_o = rsp0_val_o ? rdata_q : 8'h00;
        rsp1_data_o = rsp1_val_o ? rdata_q : 8'h00;
    end

endmodule

// File: tb/tb_i2c_arb.sv
// Directed bench for i2c_arb: scripted I2C master model plus a response scoreboard.
module tb_i2c_arb;
    localparam int MAX_RETRY = 2;
    localparam int GAP = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       req0_val_i = 0, req1_val_i = 0;
    logic       req0_rdy_o, req1_rdy_o;
    logic [6:0] req0_daddr_i = 0, req1_daddr_i = 0;
    logic [7:0] req0_addr_i = 0, req1_addr_i = 0, req0_data_i = 0, req1_data_i = 0;
    logic       req0_wen_i = 0, req1_wen_i = 0;
    logic       rsp0_val_o, rsp0_err_o, rsp1_val_o, rsp1_err_o;
    logic [7:0] rsp0_data_o, rsp1_data_o;
    logic       rsp0_rdy_i = 0, rsp1_rdy_i = 0;
    logic       m_val_o, m_wen_o, m_rdy_i;
    logic [6:0] m_daddr_o;
    logic [7:0] m_addr_o, m_data_o;
    logic       m_rsp_val_i, m_rsp_err_i, m_rsp_rdy_o, busy_o;
    logic [7:0] m_rsp_data_i;

    typedef struct {
        logic       k;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         grant_q[$];
    int         issue_cyc_q[$];
    int         cyc = 0;
    int         issue_cnt = 0;
    int         nack_base = 0;
    int         nack_n = 0;
    logic [7:0] rd_data = 8'h00;
    bit         hold_rsp = 0, drop_rsp = 0;
    logic [6:0] iss_daddr;
    logic [7:0] iss_addr, iss_data;
    logic       iss_wen;
    int         n_cmp = 0, n_mis = 0;

    i2c_arb #(.MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_val_i(req0_val_i), .req0_rdy_o(req0_rdy_o), .req0_daddr_i(req0_daddr_i),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i), .req0_wen_i(req0_wen_i),
        .req1_val_i(req1_val_i), .req1_rdy_o(req1_rdy_o), .req1_daddr_i(req1_daddr_i),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i), .req1_wen_i(req1_wen_i),
        .rsp0_val_o(rsp0_val_o), .rsp0_err_o(rsp0_err_o), .rsp0_data_o(rsp0_data_o), .rsp0_rdy_i(rsp0_rdy_i),
        .rsp1_val_o(rsp1_val_o), .rsp1_err_o(rsp1_err_o), .rsp1_data_o(rsp1_data_o), .rsp1_rdy_i(rsp1_rdy_i),
        .m_val_o(m_val_o), .m_daddr_o(m_daddr_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
        .m_wen_o(m_wen_o), .m_rdy_i(m_rdy_i),
        .m_rsp_val_i(m_rsp_val_i), .m_rsp_err_i(m_rsp_err_i), .m_rsp_data_i(m_rsp_data_i),
        .m_rsp_rdy_o(m_rsp_rdy_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (req0_rdy_o) grant_q.push_back(0);
        if (req1_rdy_o) grant_q.push_back(1);
    end

    // Master model: always ready, answers one cycle after the command handshake.
    initial begin
        m_rdy_i = 1'b1; m_rsp_val_i = 1'b0; m_rsp_err_i = 1'b0; m_rsp_data_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (m_val_o && m_rdy_i) begin
                issue_cnt++;
                issue_cyc_q.push_back(cyc);
                iss_daddr = m_daddr_o; iss_addr = m_addr_o; iss_data = m_data_o; iss_wen = m_wen_o;
                @(negedge clk_i);
                while (hold_rsp) @(negedge clk_i);
                if (drop_rsp) continue;
                m_rsp_val_i  = 1'b1;
                m_rsp_err_i  = ((issue_cnt - nack_base) <= nack_n);
                m_rsp_data_i = rd_data;
                @(negedge clk_i);
                m_rsp_val_i = 1'b0;
                m_rsp_err_i = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit k, input logic [6:0] da, input logic [7:0] ad,
                        input logic [7:0] dt, input logic we);
        int n = 0;
        @(negedge clk_i);
        if (k) begin
            req1_val_i = 1; req1_daddr_i = da; req1_addr_i = ad; req1_data_i = dt; req1_wen_i = we;
        end else begin
            req0_val_i = 1; req0_daddr_i = da; req0_addr_i = ad; req0_data_i = dt; req0_wen_i = we;
        end
        #1;
        while (!(k ? req1_rdy_o : req0_rdy_o) && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        chk("accept", 32'(k ? req1_rdy_o : req0_rdy_o), 1);
        @(negedge clk_i);
        if (k) req1_val_i = 0; else req0_val_i = 0;
    endtask

    task automatic get_rsp(input string tag, input bit drop_req);
        exp_t e;
        int n = 0;
        while (!(rsp0_val_o || rsp1_val_o) && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        chk({tag, "_seen"}, 32'(rsp0_val_o | rsp1_val_o), 1);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_val"}, 32'(e.k ? rsp1_val_o : rsp0_val_o), 1);
        chk({tag, "_other_silent"}, 32'(e.k ? rsp0_val_o : rsp1_val_o), 0);
        chk({tag, "_err"}, 32'(e.k ? rsp1_err_o : rsp0_err_o), 32'(e.err));
        chk({tag, "_data"}, 32'(e.k ? rsp1_data_o : rsp0_data_o), 32'(e.data));
        if (e.k) rsp1_rdy_i = 1; else rsp0_rdy_i = 1;
        if (drop_req) begin req0_val_i = 0; req1_val_i = 0; end
        @(negedge clk_i);
        rsp0_rdy_i = 0; rsp1_rdy_i = 0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({req0_rdy_o, req1_rdy_o, rsp0_val_o, rsp0_err_o, rsp1_val_o, rsp1_err_o,
                    m_val_o, m_wen_o, m_rsp_rdy_o, busy_o}) |
               32'({rsp0_data_o, rsp1_data_o, m_addr_o, m_data_o}) | 32'(m_daddr_o);
    endfunction

    initial begin
        int n;
        // Reset: every output low even with a request pending.
        #1 rst_ni = 0;
        req0_val_i = 1;
        repeat (2) @(negedge clk_i);
        #1 chk("reset_outputs_zero", all_outs(), 0);
        req0_val_i = 0;
        @(posedge clk_i); #2 rst_ni = 1;

        // Tie after reset goes to req0, then alternates while both stay valid.
        rd_data = 8'h11; nack_n = 0; nack_base = issue_cnt;
        grant_q.delete();
        @(negedge clk_i);
        req0_val_i = 1; req0_daddr_i = 7'h20; req0_addr_i = 8'h01; req0_wen_i = 0;
        req1_val_i = 1; req1_daddr_i = 7'h21; req1_addr_i = 8'h02; req1_wen_i = 0;
        sb_q.push_back('{1'b0, 1'b0, 8'h11}); sb_q.push_back('{1'b1, 1'b0, 8'h11});
        sb_q.push_back('{1'b0, 1'b0, 8'h11}); sb_q.push_back('{1'b1, 1'b0, 8'h11});
        for (int i = 0; i < 4; i++) get_rsp("rr", i == 3);
        chk("rr_grant_count", grant_q.size(), 4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) chk("rr_grant_order", grant_q[i], i % 2);

        // Simple write from req0 with ACK.
        rd_data = 8'h00; nack_n = 0; nack_base = issue_cnt;
        sb_q.push_back('{1'b0, 1'b0, 8'h00});
        send(0, 7'h50, 8'h10, 8'hA5, 1);
        get_rsp("wr", 0);
        chk("wr_issues", issue_cnt - nack_base, 1);
        chk("wr_m_fields", {iss_daddr, iss_addr, iss_data, iss_wen}, {7'h50, 8'h10, 8'hA5, 1'b1});
        #1 chk("idle_rsp_rdy_low", 32'(m_rsp_rdy_o), 0);
        chk("idle_not_busy", 32'(busy_o), 0);

        // NACK on every attempt: 3 issues separated by GAP idle cycles, err reported.
        rd_data = 8'h77; nack_n = 100; nack_base = issue_cnt; issue_cyc_q.delete();
        sb_q.push_back('{1'b1, 1'b1, 8'h77});
        send(1, 7'h33, 8'h44, 8'h55, 1);
        get_rsp("nack_all", 0);
        chk("nack_all_issues", issue_cnt - nack_base, MAX_RETRY + 1);
        for (int i = 1; i < issue_cyc_q.size(); i++)
            chk("nack_all_spacing", issue_cyc_q[i] - issue_cyc_q[i-1], GAP + 2);

        // One NACK then ACK on a read.
        rd_data = 8'h3C; nack_n = 1; nack_base = issue_cnt;
        sb_q.push_back('{1'b0, 1'b0, 8'h3C});
        send(0, 7'h12, 8'h34, 8'h00, 0);
        get_rsp("retry_read", 0);
        chk("retry_read_issues", issue_cnt - nack_base, 2);

        // Response back-pressure: RESP holds steady and req1 waits.
        rd_data = 8'h9D; nack_n = 0; nack_base = issue_cnt;
        send(0, 7'h40, 8'h41, 8'h42, 0);
        req1_val_i = 1; req1_daddr_i = 7'h60; req1_addr_i = 8'h61; req1_data_i = 8'h62; req1_wen_i = 1;
        n = 0;
        while (!rsp0_val_o && n < 200) begin @(negedge clk_i); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            chk("hold_rsp0", {rsp0_val_o, rsp0_err_o, rsp0_data_o, rsp1_val_o, req1_rdy_o},
                {1'b1, 1'b0, 8'h9D, 1'b0, 1'b0});
            @(negedge clk_i); #1;
        end
        rsp0_rdy_i = 1;
        @(negedge clk_i); rsp0_rdy_i = 0;
        #1 chk("b2b_req1_rdy", 32'(req1_rdy_o), 1);
        @(negedge clk_i); req1_val_i = 0;
        sb_q.push_back('{1'b1, 1'b0, 8'h9D});
        get_rsp("after_hold", 0);

        // Reset in WAIT aborts silently; next tie goes to req0.
        hold_rsp = 1;
        send(1, 7'h70, 8'h71, 8'h72, 1);
        n = 0;
        while (!m_rsp_rdy_o && n < 50) begin @(negedge clk_i); #1; n++; end
        chk("in_wait", 32'(m_rsp_rdy_o), 1);
        req0_val_i = 1; req1_val_i = 1;
        @(negedge clk_i); rst_ni = 0;
        #1 chk("midreset_outputs_zero", all_outs(), 0);
        drop_rsp = 1; hold_rsp = 0;
        repeat (2) @(negedge clk_i);
        drop_rsp = 0;
        grant_q.delete();
        @(posedge clk_i); #2 rst_ni = 1;
        @(negedge clk_i); #1;
        chk("post_reset_tie", {req0_rdy_o, req1_rdy_o}, 2'b10);
        @(negedge clk_i); req0_val_i = 0; req1_val_i = 0;
        rd_data = 8'h5E; nack_n = 0; nack_base = issue_cnt;
        sb_q.push_back('{1'b0, 1'b0, 8'h5E});
        get_rsp("post_reset", 0);
        chk("post_reset_grants", grant_q.size(), 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2: number of re-issues after a NACK (0 = no retry).
REQ-002 SHALL have parameter GAP_CYCLES, default 1000: idle clk_i cycles between a NACK response and the re-issue (minimum 1).
REQ-003 SHALL have port clk_i  in  1: sole clock, rising edge.
REQ-004 SHALL have port rst_ni  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports reqK_val_i / reqK_rdy_o  in/out  1 (K=0,1): request handshake per requester.
REQ-006 SHALL have ports reqK_daddr_i[7], reqK_addr_i[8], reqK_data_i[8], reqK_wen_i[1]  in (K=0,1): device address, register address, write data, 1=write.
REQ-007 SHALL have ports rspK_val_o out 1, rspK_err_o out 1, rspK_data_o out 8, rspK_rdy_i in 1 (K=0,1): response per requester.
REQ-008 SHALL have ports m_val_o out 1, m_daddr_o out 7, m_addr_o out 8, m_data_o out 8, m_wen_o out 1, m_rdy_i in 1: command to the I2C master.
REQ-009 SHALL have ports m_rsp_val_i in 1, m_rsp_err_i in 1, m_rsp_data_i in 8, m_rsp_rdy_o out 1: response from the I2C master.
REQ-010 SHALL have port busy_o  out 1: high whenever state != IDLE.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, GAP, RESP; exactly one transaction in flight.
REQ-012 IDLE: reqK_rdy_o SHALL be 1 only for the granted K, combinationally, and only when reqK_val_i=1; on the accept edge, latch daddr/addr/data/wen and grant, clear retry count, go ISSUE.
REQ-013 Grant SHALL be round-robin: single valid wins; both valid -> the requester other than last_grant wins.
REQ-014 last_grant SHALL update on completion of RESP, not on accept.
REQ-015 ISSUE: m_val_o=1 with latched fields held stable; on m_val_o&&m_rdy_i go WAIT next cycle.
REQ-016 WAIT: m_rsp_rdy_o=1; on m_rsp_val_i capture m_rsp_err_i and m_rsp_data_i.
REQ-017 In WAIT, err=1 and retry count < MAX_RETRY: increment retry count, load gap counter with GAP_CYCLES-1, go GAP.
REQ-018 In WAIT, err=0, or err=1 with retry count == MAX_RETRY: go RESP.
REQ-019 GAP: decrement gap counter each cycle; when it reaches 0, go ISSUE (exactly GAP_CYCLES cycles in GAP).
REQ-020 RESP: rspK_val_o=1 for the granted K only, carrying captured err/data from the last attempt; the other rsp_val SHALL stay 0.
REQ-021 RESP: on rspK_rdy_i go IDLE; back-to-back accept SHALL be possible the following cycle.
REQ-022 Retry counter width SHALL be $clog2(MAX_RETRY+1); gap counter width $clog2(GAP_CYCLES+1); no wrap permitted.
REQ-023 New reqK_val_i while busy SHALL be held off (rdy=0) and not dropped; the requester keeps val asserted.
REQ-024 m_rsp_val_i outside WAIT SHALL be ignored (m_rsp_rdy_o=0).
REQ-025 rspK_data_o SHALL be forwarded for both reads and writes; it is meaningful only for reads.

Reset
REQ-026 On rst_ni low, asynchronously: state=IDLE, retry=0, gap=0, latched fields=0, last_grant=1 (requester 0 wins first tie).
REQ-027 During reset, all outputs SHALL be 0; busy_o=0.
REQ-028 Reset mid-transaction SHALL abort with no response delivered; the I2C master shares rst_ni.

Verification
REQ-029 Req0 write daddr=0x50 addr=0x10 data=0xA5, master ACKs -> m_* carries those values, one issue, rsp0_val=1 err=0, rsp1 silent.
REQ-030 Both valid in the same cycle after reset -> req0 granted; keep both valid -> next grants alternate 1,0,1.
REQ-031 MAX_RETRY=2, GAP_CYCLES=4, master NACKs every attempt -> 3 issues, 4 idle cycles between each, rsp err=1.
REQ-032 NACK then ACK on read returning 0x3C -> 2 issues, rsp err=0 data=0x3C.
REQ-033 rstK_rdy_i held 0 for 10 cycles in RESP -> rsp val and fields stable, req1 not accepted until release.
REQ-034 rst_ni pulsed low while in WAIT -> all outputs 0 immediately, IDLE after release, next tie grants req0.
